i2s_sample_tx: RTL and testbench

- Consumer end of the sample valid/ready stream driven by the tone generators (sawtooth, sine, etc.).
- Accepts one signed mono sample per audio frame and serializes it to an external DAC as a standard I2S stream.
- The same sample is sent in both left and right slots.
- Owns the sample-rate pacing: ready_o is the generators' advance strobe, so exactly one sample is consumed per frame.

---
 rtl/i2s_sample_tx.sv | 169 ++++++++++++++++
 tb/tb_i2s_sample_tx.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_tx.sv
`timescale 1ns/1ps
// i2s_sample_tx
// Takes one signed mono sample per audio frame from a valid/ready stream and
// sends it to a DAC as I2S, with the same word in both the left and the right
// slot. ready_o acts as the sample-rate strobe for the upstream generator.
//
// Ports
//   clk_i       system clock (the only clock)
//   reset_n_i   asynchronous active-low reset
//   valid_i     sample available
//   data_i      signed sample, width_p bits
//   ready_o     holding register empty (accept on valid_i & ready_o)
//   sclk_o      I2S bit clock, period 2*clk_div_p clk_i cycles
//   lrclk_o     word select, 0 = left, 1 = right
//   sdata_o     serial data, MSB first, changes on sclk_o falling edges
//   underrun_o  one-cycle pulse when a frame starts with no new sample
//
// Build option
//   I2S_SAMPLE_TX_LJ_EN  defined: left-justified output (no one-bit delay).
//                        undefined: standard I2S one-bit delay.
module i2s_sample_tx #(
   parameter int width_p      = 12,
   parameter int slot_width_p = 16,
   parameter int clk_div_p    = 2
) (
   input  logic                      clk_i,
   input  logic                      reset_n_i,
   input  logic                      valid_i,
   input  logic signed [width_p-1:0] data_i,
   output logic                      ready_o,
   output logic                      sclk_o,
   output logic                      lrclk_o,
   output logic                      sdata_o,
   output logic                      underrun_o
);

   localparam int FRAME_BITS = 2 * slot_width_p;
   localparam int BW         = $clog2(FRAME_BITS);
   localparam int PW         = (slot_width_p > 1) ? $clog2(slot_width_p) : 1;
   localparam int DW         = (clk_div_p > 1) ? $clog2(clk_div_p) : 1;
   localparam int PAD        = slot_width_p - width_p;

   localparam logic [BW-1:0] LAST_B   = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] SLOT_B   = BW'(slot_width_p);
   localparam logic [PW-1:0] MSB_IDX  = PW'(slot_width_p - 1);
   localparam logic [DW-1:0] LAST_DIV = DW'(clk_div_p - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [DW-1:0]           r_div;
   logic                    r_sclk;
   logic                    r_lrclk;
   logic                    r_sdata;
   logic                    r_underrun;
   logic [BW-1:0]           r_b;
   logic                    r_hold_full;
   logic [slot_width_p-1:0] r_hold;
   logic [slot_width_p-1:0] r_word;

   logic                    w_hs;
   logic                    w_tick;
   logic                    w_entry;
   logic                    w_fall;
   logic [BW-1:0]           w_b_nxt;
   logic [BW-1:0]           w_b_prev;
   logic                    w_fstart;
   logic                    w_xfer;
   logic [slot_width_p-1:0] w_word_nxt;
   logic [slot_width_p-1:0] w_src_word;
   logic                    w_lr_nxt;
   logic                    w_sdata_nxt;
   logic [slot_width_p-1:0] w_cap;

   // Position of frame bit b inside its slot (b mod slot_width_p).
   function automatic logic [PW-1:0] slot_pos(input logic [BW-1:0] b);
      if (b >= SLOT_B) begin
         return PW'(b - SLOT_B);
      end
      return PW'(b);
   endfunction

   // Left-justify the sample: the zero-extended value shifted up drops the
   // extension bits and leaves zero-padded LSBs.
   assign w_cap = slot_width_p'($unsigned(data_i)) << PAD;

   assign ready_o    = reset_n_i & ~r_hold_full;
   assign sclk_o     = r_sclk;
   assign lrclk_o    = r_lrclk;
   assign sdata_o    = r_sdata;
   assign underrun_o = r_underrun;

   always_comb begin
      w_state_nxt = r_state;
      w_hs        = valid_i & ~r_hold_full;
      w_tick      = (r_div == LAST_DIV);
      // Entering RUN behaves like a falling edge that lands on bit 0.
      w_entry     = (r_state == ST_IDLE) & r_hold_full;
      w_fall      = w_entry | ((r_state == ST_RUN) & w_tick & r_sclk);
      w_b_nxt     = (w_entry || (r_b == LAST_B)) ? '0 : r_b + BW'(1);
      w_b_prev    = (w_b_nxt == '0) ? LAST_B : w_b_nxt - BW'(1);
      w_fstart    = w_fall & (w_b_nxt == '0);
      w_xfer      = w_fstart & r_hold_full;
      w_word_nxt  = w_xfer ? r_hold : r_word;
      w_lr_nxt    = (w_b_nxt >= SLOT_B);
`ifdef I2S_SAMPLE_TX_LJ_EN
      w_src_word  = w_word_nxt;
      w_sdata_nxt = w_src_word[MSB_IDX - slot_pos(w_b_nxt)];
`else
      // At bit 0 the delayed bit is the previous frame's right-slot LSB,
      // so it must come from the word that is being replaced.
      w_src_word  = (w_b_nxt == '0) ? r_word : w_word_nxt;
      w_sdata_nxt = w_src_word[MSB_IDX - slot_pos(w_b_prev)];
`endif
      if ((r_state == ST_IDLE) && r_hold_full) begin
         w_state_nxt = ST_RUN;
      end
   end

   // Control and serializer state
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= ST_IDLE;
         r_div       <= '0;
         r_sclk      <= 1'b0;
         r_lrclk     <= 1'b0;
         r_sdata     <= 1'b0;
         r_underrun  <= 1'b0;
         r_b         <= '0;
         r_hold_full <= 1'b0;
         r_word      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_underrun <= w_fstart & ~r_hold_full;
         if (r_state == ST_RUN) begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
               r_sclk <= ~r_sclk;
            end
         end
         if (w_fall) begin
            r_b     <= w_b_nxt;
            r_lrclk <= w_lr_nxt;
            r_sdata <= w_sdata_nxt;
            r_word  <= w_word_nxt;
         end
         // Transfer and capture never coincide: capture needs the flag clear,
         // transfer needs it set.
         if (w_xfer) begin
            r_hold_full <= 1'b0;
         end else if (w_hs) begin
            r_hold_full <= 1'b1;
         end
      end
   end

   // Holding register data
   always_ff @(posedge clk_i) begin
      if (w_hs) begin
         r_hold <= w_cap;
      end
   end

endmodule

// File: tb/tb_i2s_sample_tx.sv
`timescale 1ns/1ps
module tb_i2s_sample_tx;

   localparam int W          = 12;
   localparam int S          = 16;
   localparam int D          = 2;
   localparam int BIT_CLKS   = 2 * D;
   localparam int FRAME_CLKS = 2 * S * BIT_CLKS;

   logic                clk_i = 1'b0;
   logic                reset_n_i;
   logic                valid_i;
   logic signed [W-1:0] data_i;
   logic                ready_o;
   logic                sclk_o;
   logic                lrclk_o;
   logic                sdata_o;
   logic                underrun_o;

   i2s_sample_tx #(.width_p(W), .slot_width_p(S), .clk_div_p(D)) dut (
      .clk_i      (clk_i),
      .reset_n_i  (reset_n_i),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .ready_o    (ready_o),
      .sclk_o     (sclk_o),
      .lrclk_o    (lrclk_o),
      .sdata_o    (sdata_o),
      .underrun_o (underrun_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [W-1:0] data;
      logic [S-1:0] word;
   } vec_t;

   vec_t vecs [7];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: time since RUN entry, plus the words per frame.
   bit           m_run;
   int           m_k;
   bit           m_hf;
   logic [S-1:0] m_hold;
   logic [S-1:0] m_word;
   logic [S-1:0] m_prev;
   bit           m_under;
   logic [S-1:0] m_hold_exp;
   logic [S-1:0] m_frame_exp;
   int           m_hs = 0;

   logic [S-1:0] drv_exp;
   logic [S-1:0] cap;
   bit           last_ready = 1'b0;
   int           dut_hs = 0;
   int           n_under_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
      end
   endtask

   function automatic int cur_bit();
      return (m_k / BIT_CLKS) % (2 * S);
   endfunction

   function automatic logic model_sd();
      int bt;
      bt = cur_bit();
`ifdef I2S_SAMPLE_TX_LJ_EN
      return m_word[S - 1 - (bt % S)];
`else
      if (bt == 0) return m_prev[0];
      return m_word[S - 1 - ((bt - 1) % S)];
`endif
   endfunction

   task automatic model_reset();
      m_run = 0; m_k = 0; m_hf = 0; m_hold = '0; m_word = '0; m_prev = '0;
      m_under = 0; m_hold_exp = '0; m_frame_exp = '0; cap = '0;
   endtask

   task automatic model_edge();
      bit hs;
      bit fs;
      if (!reset_n_i) begin
         model_reset();
         return;
      end
      if (valid_i && last_ready) dut_hs++;
      hs = valid_i && !m_hf;
      fs = 0;
      m_under = 0;
      if (!m_run) begin
         if (m_hf) begin
            m_run = 1;
            m_k = 0;
            fs = 1;
         end
      end else begin
         m_k++;
         if (m_k % FRAME_CLKS == 0) fs = 1;
      end
      if (fs) begin
         m_prev = m_word;
         if (m_hf) begin
            m_word = m_hold;
            m_frame_exp = m_hold_exp;
            m_hf = 0;
         end else begin
            m_under = 1;
         end
      end
      if (hs) begin
         m_hf = 1;
         m_hold = {data_i, {(S - W){1'b0}}};
         m_hold_exp = drv_exp;
         m_hs++;
      end
   endtask

   task automatic check_outputs();
      int bt;
      bt = cur_bit();
      chk("sclk",     sclk_o,     m_run && ((m_k % BIT_CLKS) >= D));
      chk("lrclk",    lrclk_o,    m_run && (bt >= S));
      chk("sdata",    sdata_o,    m_run ? model_sd() : 1'b0);
      chk("underrun", underrun_o, m_under);
      chk("ready",    ready_o,    reset_n_i && !m_hf);
      last_ready = ready_o;
      if (underrun_o === 1'b1) n_under_seen++;
      // Rebuild the left-slot word from the line, mid-bit.
      if (m_run && (m_k % BIT_CLKS) == D) begin
`ifdef I2S_SAMPLE_TX_LJ_EN
         if (bt <= S - 1) cap[S - 1 - bt] = sdata_o;
         if (bt == S - 1) chk("left_word", cap, m_frame_exp);
`else
         if (bt >= 1 && bt <= S) cap[S - bt] = sdata_o;
         if (bt == S) chk("left_word", cap, m_frame_exp);
`endif
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic feed(input logic [W-1:0] d, input logic [S-1:0] e);
      int start;
      start = m_hs;
      valid_i = 1'b1;
      data_i = d;
      drv_exp = e;
      for (int i = 0; i < 400 && m_hs == start; i++) step();
      if (m_hs == start) chk("feed_timeout", 0, 1);
      valid_i = 1'b0;
   endtask

   task automatic do_reset();
      #2;
      reset_n_i = 1'b0;
      valid_i = 1'b0;
      for (int i = 0; i < 3; i++) step();
      #2;
      reset_n_i = 1'b1;
      for (int i = 0; i < 10; i++) step();
   endtask

   initial begin
      int h0;
      int u0;
      bit found;
      vecs[0] = '{12'h7FF, 16'h7FF0};
      vecs[1] = '{12'h800, 16'h8000};
      vecs[2] = '{12'h001, 16'h0010};
      vecs[3] = '{12'hFFF, 16'hFFF0};
      vecs[4] = '{12'h555, 16'h5550};
      vecs[5] = '{12'hA5A, 16'hA5A0};
      vecs[6] = '{12'h000, 16'h0000};

      model_reset();
      reset_n_i = 1'b0;
      valid_i = 1'b0;
      data_i = '0;
      drv_exp = '0;
      #1;
      chk("rst_ready", ready_o, 0);
      chk("rst_sclk", sclk_o, 0);
      chk("rst_sdata", sdata_o, 0);
      for (int i = 0; i < 3; i++) step();
      #2;
      reset_n_i = 1'b1;
      #1;
      chk("rst_release_ready", ready_o, 1);
      for (int i = 0; i < 40; i++) step();

      // Streaming table: one word per frame, captured off the line.
      for (int v = 0; v < 7; v++) begin
         feed(vecs[v].data, vecs[v].word);
      end
      for (int i = 0; i < 2 * FRAME_CLKS; i++) step();

      // Two samples across two frames.
      do_reset();
      h0 = dut_hs;
      feed(12'h800, 16'h8000);
      feed(12'h001, 16'h0010);
      for (int i = 0; i < 2 * FRAME_CLKS + 40; i++) step();
      chk("two_handshakes", dut_hs - h0, 2);

      // Single sample then starvation.
      do_reset();
      u0 = n_under_seen;
      feed(12'h555, 16'h5550);
      for (int i = 0; i < 3 * FRAME_CLKS + 8; i++) step();
      chk("underrun_count", n_under_seen - u0, 3);

      // Reset in the middle of the right slot (b = 20).
      found = 0;
      for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
         step();
         if (m_run && cur_bit() == 20 && (m_k % BIT_CLKS) == 0) found = 1;
      end
      chk("found_b20", found, 1);
      #2;
      reset_n_i = 1'b0;
      #1;
      chk("async_rst_ready", ready_o, 0);
      chk("async_rst_sclk", sclk_o, 0);
      chk("async_rst_lrclk", lrclk_o, 0);
      chk("async_rst_sdata", sdata_o, 0);
      chk("async_rst_underrun", underrun_o, 0);
      for (int i = 0; i < 3; i++) step();
      #2;
      reset_n_i = 1'b1;
      for (int i = 0; i < 20; i++) step();

      // Random traffic with occasional starvation.
      for (int i = 0; i < 3000; i++) begin
         valid_i = ($urandom_range(0, 9) < 7);
         data_i = W'($urandom);
         drv_exp = {data_i, {(S - W){1'b0}}};
         step();
      end
      valid_i = 1'b0;
      for (int i = 0; i < FRAME_CLKS; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
